// File: rtl/data_mem_responder.sv
// Data-memory responder: memory end of the CPU data-memory interface.
// Serves b/h/w loads and stores (RISC-V funct3 op encoding), inserts
// WAIT_CYCLES wait states and splits word-crossing accesses into two
// word accesses.
//
// Ports:
//   clk    clock, rising edge
//   rst    asynchronous active-low reset
//   req    request valid, sampled while busy=0
//   we     1 = store, 0 = load
//   addr   byte address
//   op     000 b, 001 h, 010 w, 100 bu, 101 hu
//   wdata  store data, right-justified
//   busy   request in progress
//   ready  one-cycle response strobe
//   rdata  load result while ready=1, else 0
//   err    error flag while ready=1, else 0
module data_mem_responder #(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned WAIT_CYCLES    = 1,
  parameter bit          ALLOW_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [2:0]  op,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACC0,
    ACC1,
    RESP
  } stateType;

  // Access size in bytes from op[1:0]
  function automatic logic [2:0] sizeOf(input logic [1:0] sz);
    case (sz)
      2'b00:   sizeOf = 3'd1;
      2'b01:   sizeOf = 3'd2;
      default: sizeOf = 3'd4;
    endcase
  endfunction

  // Byte-lane mask of an access anchored at lane 0
  function automatic logic [3:0] maskOf(input logic [1:0] sz);
    case (sz)
      2'b00:   maskOf = 4'b0001;
      2'b01:   maskOf = 4'b0011;
      default: maskOf = 4'b1111;
    endcase
  endfunction

  logic [31:0] mem [DEPTH];

  stateType             state, stateNext;
  logic [CNT_W-1:0]     waitCnt, waitCntNext;
  logic [1:0]           offQ;
  logic [ADDR_W-1:0]    idxQ;
  logic                 weQ;
  logic [2:0]           opQ;
  logic [31:0]          wdataQ;
  logic                 errQ;
  logic                 crossQ;
  logic [31:0]          lowWordQ;

  logic                 busyNext, readyNext, errNext;
  logic [31:0]          rdataNext;
  logic                 accept;

  logic [2:0]           reqSize;
  logic                 reqCross, reqIllegal, reqRange, reqMisalign, reqErr;

  logic [ADDR_W-1:0]    memIdx;
  logic [31:0]          memRd;
  logic                 memWe;
  logic [3:0]           memLanes;
  logic [31:0]          memWdata, memMerged;
  logic [63:0]          loadWin, storeWin;
  logic [7:0]           laneMask;
  logic [31:0]          loadRaw, loadVal;

  // Request classification on the live inputs, used at the accept edge
  always_comb begin
    reqSize     = sizeOf(op[1:0]);
    reqCross    = (3'(addr[1:0]) + reqSize) > 3'd4;
    reqIllegal  = (op == 3'b011) || (op[2:1] == 2'b11) || (we && op[2]);
    // A crossing access in the last word would wrap onto word 0
    reqRange    = ((addr >> (ADDR_W + 2)) != 32'd0) ||
                  (reqCross && (addr[ADDR_W+1:2] == '1));
    reqMisalign = ((reqSize == 3'd2) && addr[0]) ||
                  ((reqSize == 3'd4) && (addr[1:0] != 2'b00));
    reqErr      = reqIllegal || reqRange || (!ALLOW_MISALIGN && reqMisalign);
  end

  // Datapath: the access is viewed as a 64-bit window over two adjacent words
  always_comb begin
    memIdx   = (state == ACC1) ? idxQ + ADDR_W'(1) : idxQ;
    memRd    = mem[memIdx];
    loadWin  = (state == ACC1) ? {memRd, lowWordQ} : {32'd0, memRd};
    loadRaw  = 32'(loadWin >> {offQ, 3'b000});
    case (opQ)
      3'b000:  loadVal = {{24{loadRaw[7]}}, loadRaw[7:0]};
      3'b001:  loadVal = {{16{loadRaw[15]}}, loadRaw[15:0]};
      3'b100:  loadVal = {24'd0, loadRaw[7:0]};
      3'b101:  loadVal = {16'd0, loadRaw[15:0]};
      default: loadVal = loadRaw;
    endcase
    storeWin = 64'(wdataQ) << {offQ, 3'b000};
    laneMask = 8'(maskOf(opQ[1:0])) << offQ;
    memLanes = (state == ACC1) ? laneMask[7:4] : laneMask[3:0];
    memWdata = (state == ACC1) ? storeWin[63:32] : storeWin[31:0];
    for (int k = 0; k < 4; k++) begin
      memMerged[8*k +: 8] = memLanes[k] ? memWdata[8*k +: 8] : memRd[8*k +: 8];
    end
  end

  // Next-state and next-output logic
  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    busyNext    = 1'b0;
    readyNext   = 1'b0;
    rdataNext   = 32'd0;
    errNext     = 1'b0;
    memWe       = 1'b0;
    accept      = 1'b0;
    unique case (state)
      IDLE, RESP: begin
        if (req) begin
          accept      = 1'b1;
          busyNext    = 1'b1;
          waitCntNext = CNT_W'(WAIT_CYCLES - 1);
          // Errors spend one cycle in ACC0 without touching memory
          if (reqErr || (WAIT_CYCLES == 0)) stateNext = ACC0;
          else                              stateNext = WAIT;
        end else begin
          stateNext = IDLE;
        end
      end
      WAIT: begin
        busyNext = 1'b1;
        if (waitCnt == '0) stateNext   = ACC0;
        else               waitCntNext = waitCnt - CNT_W'(1);
      end
      ACC0: begin
        if (errQ) begin
          stateNext = RESP;
          readyNext = 1'b1;
          errNext   = 1'b1;
        end else begin
          memWe = weQ;
          if (crossQ) begin
            stateNext = ACC1;
            busyNext  = 1'b1;
          end else begin
            stateNext = RESP;
            readyNext = 1'b1;
            rdataNext = weQ ? 32'd0 : loadVal;
          end
        end
      end
      ACC1: begin
        memWe     = weQ;
        stateNext = RESP;
        readyNext = 1'b1;
        rdataNext = weQ ? 32'd0 : loadVal;
      end
      default: stateNext = IDLE;
    endcase
  end

  // State, registered outputs and latched request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      waitCnt  <= '0;
      busy     <= 1'b0;
      ready    <= 1'b0;
      rdata    <= 32'd0;
      err      <= 1'b0;
      offQ     <= 2'b00;
      idxQ     <= '0;
      weQ      <= 1'b0;
      opQ      <= 3'b000;
      wdataQ   <= 32'd0;
      errQ     <= 1'b0;
      crossQ   <= 1'b0;
      lowWordQ <= 32'd0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      busy    <= busyNext;
      ready   <= readyNext;
      rdata   <= rdataNext;
      err     <= errNext;
      if (accept) begin
        offQ   <= addr[1:0];
        idxQ   <= addr[ADDR_W+1:2];
        weQ    <= we;
        opQ    <= op;
        wdataQ <= wdata;
        errQ   <= reqErr;
        crossQ <= reqCross && !reqErr;
      end
      if (state == ACC0) lowWordQ <= memRd;
    end
  end

  // Memory array, not reset; writes only happen from ACC0/ACC1
  always_ff @(posedge clk) begin
    if (memWe) mem[memIdx] <= memMerged;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: a misalign-capable instance
// (dut) and a strict-alignment instance (dutNm), both with two wait states.
module tb_data_mem_responder;

  localparam int unsigned ADDR_W      = 10;
  localparam int unsigned WAIT_CYCLES = 2;
  localparam int LAT_A = 3;  // aligned: E(WAIT_CYCLES+1)
  localparam int LAT_C = 4;  // crossing: E(WAIT_CYCLES+2)
  localparam int LAT_E = 1;  // error: E1

  logic        clk = 1'b0;
  logic        rst, req, req2, we;
  logic [31:0] addr, wdata;
  logic [2:0]  op;
  logic        busy, ready, err, busy2, ready2, err2;
  logic [31:0] rdata, rdata2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    string       name;
  } expT;
  expT sbq[$];

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES), .ALLOW_MISALIGN(1'b1)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .op(op), .wdata(wdata),
    .busy(busy), .ready(ready), .rdata(rdata), .err(err)
  );

  data_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT_CYCLES), .ALLOW_MISALIGN(1'b0)) dutNm (
    .clk(clk), .rst(rst), .req(req2), .we(we), .addr(addr), .op(op), .wdata(wdata),
    .busy(busy2), .ready(ready2), .rdata(rdata2), .err(err2)
  );

  // Wait for the response of the oldest scoreboard entry and compare it
  task automatic collect(input bit sel);
    expT         e;
    int          n;
    bit          got;
    logic        rdy, bsy, er;
    logic [31:0] rd;
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      rdy = sel ? ready2 : ready;
      bsy = sel ? busy2 : busy;
      if (rdy === 1'b1) begin
        got = 1'b1;
      end else begin
        checks++;
        if (bsy !== 1'b1) begin
          errors++;
          $display("FAIL busy_wait: cycle %0d busy=%b, expected 1", n, bsy);
        end
      end
    end
    e = sbq.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout: no ready within %0d cycles, expected after %0d", e.name, n, e.lat);
    end else begin
      rd  = sel ? rdata2 : rdata;
      er  = sel ? err2 : err;
      bsy = sel ? busy2 : busy;
      if (rd !== e.rdata) begin
        errors++;
        $display("FAIL %s_rdata: got %h, expected %h", e.name, rd, e.rdata);
      end
      checks++;
      if (er !== e.err) begin
        errors++;
        $display("FAIL %s_err: got %b, expected %b", e.name, er, e.err);
      end
      checks++;
      if (n != e.lat) begin
        errors++;
        $display("FAIL %s_latency: got %0d edges, expected %0d", e.name, n, e.lat);
      end
      checks++;
      if (bsy !== 1'b0) begin
        errors++;
        $display("FAIL %s_busy_resp: got %b, expected 0", e.name, bsy);
      end
    end
  endtask

  // Drive one request, push its expectation, then collect the response
  task automatic issue(input bit sel, input bit hold, input logic w, input logic [31:0] a,
                       input logic [2:0] o, input logic [31:0] d, input logic [31:0] expR,
                       input logic expE, input int expLat, input string name);
    expT  e;
    logic bsy;
    @(negedge clk);
    we = w; addr = a; op = o; wdata = d;
    if (sel) req2 = 1'b1;
    else     req  = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      req  = 1'b0;
      req2 = 1'b0;
    end
    e.rdata = expR; e.err = expE; e.lat = expLat; e.name = name;
    sbq.push_back(e);
    bsy = sel ? busy2 : busy;
    checks++;
    if (bsy !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy_e0: got %b, expected 1", name, bsy);
    end
    collect(sel);
  endtask

  task automatic test_reset();
    rst = 1'b0; req = 1'b0; req2 = 1'b0; we = 1'b0;
    addr = 32'd0; op = 3'b000; wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, ready, err, rdata} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b ready=%b err=%b rdata=%h, expected all 0", busy, ready, err, rdata);
    end
    checks++;
    if ({busy2, ready2, err2, rdata2} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs_nm: busy=%b ready=%b err=%b rdata=%h, expected all 0", busy2, ready2, err2, rdata2);
    end
    @(negedge clk);
    rst = 1'b1;
    issue(0, 0, 1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 0, LAT_A, "sw_10");
  endtask

  task automatic test_extension();
    issue(0, 0, 0, 32'h13, 3'b000, 32'h0, 32'hFFFFFFDE, 0, LAT_A, "lb_13");
    issue(0, 0, 0, 32'h11, 3'b100, 32'h0, 32'h000000BE, 0, LAT_A, "lbu_11");
    issue(0, 0, 0, 32'h12, 3'b001, 32'h0, 32'hFFFFDEAD, 0, LAT_A, "lh_12");
    issue(0, 0, 0, 32'h10, 3'b101, 32'h0, 32'h0000BEEF, 0, LAT_A, "lhu_10");
  endtask

  task automatic test_partial_store();
    issue(0, 0, 1, 32'h11, 3'b000, 32'hFFFFFF5A, 32'h0, 0, LAT_A, "sb_11");
    issue(0, 0, 0, 32'h10, 3'b010, 32'h0, 32'hDEAD5AEF, 0, LAT_A, "lw_after_sb");
    issue(0, 0, 1, 32'h12, 3'b001, 32'hFFFF1234, 32'h0, 0, LAT_A, "sh_12");
    issue(0, 0, 0, 32'h10, 3'b010, 32'h0, 32'h12345AEF, 0, LAT_A, "lw_after_sh");
  endtask

  task automatic test_crossing();
    issue(0, 0, 1, 32'h14, 3'b010, 32'h11223344, 32'h0, 0, LAT_A, "sw_14");
    issue(0, 0, 0, 32'h12, 3'b010, 32'h0, 32'h33441234, 0, LAT_C, "lw_cross_12");
    issue(0, 0, 1, 32'h18, 3'b010, 32'h0, 32'h0, 0, LAT_A, "sw_18");
    issue(0, 0, 1, 32'h17, 3'b001, 32'h9999ABCD, 32'h0, 0, LAT_C, "sh_cross_17");
    issue(0, 0, 0, 32'h14, 3'b010, 32'h0, 32'hCD223344, 0, LAT_A, "lw_14_after_sh");
    issue(0, 0, 0, 32'h18, 3'b010, 32'h0, 32'h000000AB, 0, LAT_A, "lw_18_after_sh");
    issue(0, 0, 0, 32'h11, 3'b001, 32'h0, 32'h0000345A, 0, LAT_A, "lh_misal_11");
  endtask

  task automatic test_errors();
    issue(0, 0, 0, 32'h10, 3'b011, 32'h0, 32'h0, 1, LAT_E, "op_011");
    issue(0, 0, 1, 32'h10, 3'b100, 32'h0, 32'h0, 1, LAT_E, "store_op_100");
    issue(0, 0, 1, 32'h0, 3'b010, 32'hA5A5A5A5, 32'h0, 0, LAT_A, "sw_0");
    issue(0, 0, 1, 32'(4 << ADDR_W), 3'b010, 32'h0BADF00D, 32'h0, 1, LAT_E, "sw_out_of_range");
    issue(0, 0, 0, 32'h0, 3'b010, 32'h0, 32'hA5A5A5A5, 0, LAT_A, "lw_0_unchanged");
    issue(0, 0, 0, 32'((4 << ADDR_W) - 2), 3'b010, 32'h0, 32'h0, 1, LAT_E, "lw_cross_last_word");
    issue(0, 0, 0, 32'h10, 3'b010, 32'h0, 32'h12345AEF, 0, LAT_A, "lw_10_after_errs");
  endtask

  task automatic test_no_misalign();
    issue(1, 0, 1, 32'h8, 3'b010, 32'h55AA55AA, 32'h0, 0, LAT_A, "nm_sw_8");
    issue(1, 0, 0, 32'h8, 3'b010, 32'h0, 32'h55AA55AA, 0, LAT_A, "nm_lw_8");
    issue(1, 0, 0, 32'h12, 3'b010, 32'h0, 32'h0, 1, LAT_E, "nm_lw_cross_12");
    issue(1, 0, 0, 32'h11, 3'b001, 32'h0, 32'h0, 1, LAT_E, "nm_lh_11");
  endtask

  task automatic test_back_to_back();
    expT e;
    issue(0, 1, 1, 32'h40, 3'b010, 32'hCAFEF00D, 32'h0, 0, LAT_A, "b2b_sw_40");
    // still in RESP with req high: present the next request now
    we = 1'b0; addr = 32'h40; op = 3'b010; wdata = 32'h0;
    @(posedge clk);
    #1;
    req = 1'b0;
    e.rdata = 32'hCAFEF00D; e.err = 1'b0; e.lat = LAT_A; e.name = "b2b_lw_40";
    sbq.push_back(e);
    collect(0);
  endtask

  task automatic test_req_held();
    int pulses;
    issue(0, 1, 0, 32'h13, 3'b000, 32'h0, 32'h00000012, 0, LAT_A, "held_lb_13");
    req = 1'b0;
    pulses = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (ready === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL held_extra_ready: got %0d extra pulses, expected 0", pulses);
    end
  endtask

  task automatic test_reset_mid_op();
    bit sawReady;
    issue(0, 0, 1, 32'h20, 3'b010, 32'h01020304, 32'h0, 0, LAT_A, "sw_20");
    @(negedge clk);
    we = 1'b1; addr = 32'h20; op = 3'b000; wdata = 32'h77; req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: busy=%b ready=%b, expected 0 0", busy, ready);
    end
    sawReady = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (ready !== 1'b0) sawReady = 1'b1;
    end
    checks++;
    if (sawReady) begin
      errors++;
      $display("FAIL midrst_ready: ready pulsed during reset, expected none");
    end
    @(negedge clk);
    rst = 1'b1;
    issue(0, 0, 0, 32'h20, 3'b010, 32'h0, 32'h01020304, 0, LAT_A, "lw_20_after_rst");
  endtask

  initial begin
    test_reset();
    test_extension();
    test_partial_store();
    test_crossing();
    test_errors();
    test_no_misalign();
    test_back_to_back();
    test_req_held();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
